// File: rtl/fir_out_fifo_if.sv
// rtl/fir_out_fifo_if.sv - handshake/bus bundle between the FIR output FIFO and its producer/consumer
//
// Purpose: groups the FIFO's stream-side and status signals into one interface.
// Ports (signals):
//   EN       global enable (freezes all FIFO state when low)
//   R_IN     input sample valid pulse from the filter
//   D_IN     input sample (N bits, two's-complement, stored unmodified)
//   RD       consumer ready
//   CLR_OVF  synchronous clear of the sticky overflow flag
//   R_OUT    output valid (FIFO not empty)
//   D_OUT    head-of-FIFO sample, 0 when empty
//   COUNT    registered fill level, 0..DEPTH
//   FULL     COUNT == DEPTH
//   EMPTY    COUNT == 0
//   OVF      sticky flag: a kept sample was dropped
// Modports: master = producer/consumer side, slave = FIFO side.
interface fir_out_fifo_if #(
  parameter int N     = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          EN;
  logic          R_IN;
  logic [N-1:0]  D_IN;
  logic          RD;
  logic          CLR_OVF;
  logic          R_OUT;
  logic [N-1:0]  D_OUT;
  logic [CW-1:0] COUNT;
  logic          FULL;
  logic          EMPTY;
  logic          OVF;

  modport master (
    output EN, R_IN, D_IN, RD, CLR_OVF,
    input  R_OUT, D_OUT, COUNT, FULL, EMPTY, OVF
  );

  modport slave (
    input  EN, R_IN, D_IN, RD, CLR_OVF,
    output R_OUT, D_OUT, COUNT, FULL, EMPTY, OVF
  );
endinterface

// File: rtl/fir_out_fifo.sv
// rtl/fir_out_fifo.sv - decimating circular output FIFO behind the FIR filter datapath
//
// Purpose: keeps one of every DECIM valid filter samples, buffers them in a
// DEPTH-entry circular store and hands them to a consumer with valid/ready,
// so a stalling sink never back-pressures the free-running filter.
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-low reset (clears pointers, count, phase, OVF)
//   bus  fir_out_fifo_if.slave: EN, R_IN, D_IN, RD, CLR_OVF in;
//        R_OUT, D_OUT, COUNT, FULL, EMPTY, OVF out
module fir_out_fifo #(
  parameter int N     = 16,
  parameter int DEPTH = 8,
  parameter int DECIM = 1
) (
  input  logic          CLK,
  input  logic          RST,
  fir_out_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          ovf_q, ovf_d;

  logic full, empty, pop, keep, push, drop;

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    pop   = bus.EN && bus.RD && !empty;
    keep  = bus.EN && bus.R_IN && (phase_q == '0);
    // A full FIFO still accepts a kept sample when the head leaves this cycle.
    push  = keep && (!full || pop);
    drop  = keep && full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    phase_d  = phase_q;
    ovf_d    = ovf_q;

    // Phase advances on every enabled valid sample, kept or not.
    if (bus.EN && bus.R_IN) begin
      phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // Setting wins over a same-cycle clear so a drop is never missed.
    if (drop)                         ovf_d = 1'b1;
    else if (bus.EN && bus.CLR_OVF)   ovf_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      phase_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.D_IN;
  end

  assign bus.R_OUT = !empty;
  assign bus.D_OUT = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.COUNT = count_q;
  assign bus.FULL  = full;
  assign bus.EMPTY = empty;
  assign bus.OVF   = ovf_q;
endmodule

// File: tb/tb_fir_out_fifo.sv
// tb/tb_fir_out_fifo.sv - self-checking bench for fir_out_fifo
module tb_fir_out_fifo;
  localparam int N       = 16;
  localparam int DEPTH   = 8;
  localparam int DECIM_A = 1;
  localparam int DECIM_B = 3;

  logic clk;
  logic rst_n;

  fir_out_fifo_if #(.N(N), .DEPTH(DEPTH)) ifa ();
  fir_out_fifo_if #(.N(N), .DEPTH(DEPTH)) ifb ();

  fir_out_fifo #(.N(N), .DEPTH(DEPTH), .DECIM(DECIM_A)) dut_a (
    .CLK (clk),
    .RST (rst_n),
    .bus (ifa)
  );

  fir_out_fifo #(.N(N), .DEPTH(DEPTH), .DECIM(DECIM_B)) dut_b (
    .CLK (clk),
    .RST (rst_n),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] mq[$];
  int           mphase = 0;
  bit           movf   = 1'b0;

  typedef struct {
    logic         en;
    logic         rin;
    logic [N-1:0] din;
    logic         rd;
    logic         clr;
    int           exp_count;
    logic         exp_rout;
    logic [N-1:0] exp_dout;
    logic         exp_ovf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    mphase = 0;
    movf   = 1'b0;
  endtask

  // Reference: queue semantics straight from the FIFO rules.
  task automatic model_step(input logic en, input logic rin, input logic [N-1:0] din,
                            input logic rd, input logic clr);
    bit keep;
    bit set_ovf;
    keep    = 1'b0;
    set_ovf = 1'b0;
    if (en) begin
      keep = rin && (mphase == 0);
      if (rin) mphase = (mphase + 1) % DECIM_A;
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (keep) begin
        if (mq.size() < DEPTH) mq.push_back(din);
        else set_ovf = 1'b1;
      end
      if (set_ovf) movf = 1'b1;
      else if (clr) movf = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, " COUNT"}, int'(ifa.COUNT), sz);
    chk({tag, " R_OUT"}, int'(ifa.R_OUT), int'(sz > 0));
    chk({tag, " D_OUT"}, int'(ifa.D_OUT), (sz > 0) ? int'(mq[0]) : 0);
    chk({tag, " FULL"},  int'(ifa.FULL),  int'(sz == DEPTH));
    chk({tag, " EMPTY"}, int'(ifa.EMPTY), int'(sz == 0));
    chk({tag, " OVF"},   int'(ifa.OVF),   int'(movf));
  endtask

  task automatic cycle_a(input logic en, input logic rin, input logic [N-1:0] din,
                         input logic rd, input logic clr, input string tag);
    ifa.EN = en; ifa.R_IN = rin; ifa.D_IN = din; ifa.RD = rd; ifa.CLR_OVF = clr;
    model_step(en, rin, din, rd, clr);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic cycle_b(input logic en, input logic rin, input logic [N-1:0] din,
                         input logic rd);
    ifb.EN = en; ifb.R_IN = rin; ifb.D_IN = din; ifb.RD = rd; ifb.CLR_OVF = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 1, 1'b1, 16'h1111, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 2, 1'b1, 16'h1111, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'h3333, 1'b1, 1'b0, 2, 1'b1, 16'h1111, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b1, 16'h2222, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 16'h4444, 1'b1, 1'b0, 1, 1'b1, 16'h4444, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 1'b0};

    rst_n = 1'b0;
    ifa.EN = 1'b0; ifa.R_IN = 1'b0; ifa.D_IN = '0; ifa.RD = 1'b0; ifa.CLR_OVF = 1'b0;
    ifb.EN = 1'b0; ifb.R_IN = 1'b0; ifb.D_IN = '0; ifb.RD = 1'b0; ifb.CLR_OVF = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset B EMPTY", int'(ifb.EMPTY), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven basic vectors.
    for (int i = 0; i < 7; i++) begin
      cycle_a(tbl[i].en, tbl[i].rin, tbl[i].din, tbl[i].rd, tbl[i].clr, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d count", i), int'(ifa.COUNT), tbl[i].exp_count);
      chk($sformatf("tbl%0d rout", i),  int'(ifa.R_OUT), int'(tbl[i].exp_rout));
      chk($sformatf("tbl%0d dout", i),  int'(ifa.D_OUT), int'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d ovf", i),   int'(ifa.OVF),   int'(tbl[i].exp_ovf));
    end

    // Ordering and latency.
    for (int i = 1; i <= 5; i++) cycle_a(1'b1, 1'b1, N'(i), 1'b0, 1'b0, "order fill");
    chk("order count5", int'(ifa.COUNT), 5);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("order head%0d", i), int'(ifa.D_OUT), i);
      cycle_a(1'b1, 1'b0, '0, 1'b1, 1'b0, "order drain");
      chk($sformatf("order count after pop%0d", i), int'(ifa.COUNT), 5 - i);
    end
    chk("order empty", int'(ifa.EMPTY), 1);

    // Overflow.
    for (int i = 0; i < 9; i++) cycle_a(1'b1, 1'b1, 16'hA000 + N'(i), 1'b0, 1'b0, "ovf fill");
    chk("ovf FULL", int'(ifa.FULL), 1);
    chk("ovf COUNT", int'(ifa.COUNT), 8);
    chk("ovf OVF", int'(ifa.OVF), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf drain%0d", i), int'(ifa.D_OUT), 16'hA000 + i);
      cycle_a(1'b1, 1'b0, '0, 1'b1, 1'b0, "ovf drain");
    end
    chk("ovf drained empty", int'(ifa.EMPTY), 1);
    chk("ovf held", int'(ifa.OVF), 1);
    cycle_a(1'b1, 1'b0, '0, 1'b0, 1'b1, "ovf clr");
    chk("ovf cleared", int'(ifa.OVF), 0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) cycle_a(1'b1, 1'b1, 16'hB000 + N'(i), 1'b0, 1'b0, "pp fill");
    for (int i = 0; i < 20; i++) begin
      cycle_a(1'b1, 1'b1, 16'hB008 + N'(i), 1'b1, 1'b0, "pp run");
      chk($sformatf("pp head%0d", i), int'(ifa.D_OUT), 16'hB001 + i);
      chk($sformatf("pp count%0d", i), int'(ifa.COUNT), 8);
      chk($sformatf("pp ovf%0d", i), int'(ifa.OVF), 0);
    end
    for (int i = 0; i < 8; i++) cycle_a(1'b1, 1'b0, '0, 1'b1, 1'b0, "pp drain");

    // Enable freeze.
    cycle_a(1'b1, 1'b1, 16'hC001, 1'b0, 1'b0, "frz fill");
    cycle_a(1'b1, 1'b1, 16'hC002, 1'b0, 1'b0, "frz fill");
    for (int i = 0; i < 4; i++) begin
      cycle_a(1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0, "frz hold");
      chk($sformatf("frz count%0d", i), int'(ifa.COUNT), 2);
      chk($sformatf("frz dout%0d", i), int'(ifa.D_OUT), 16'hC001);
    end
    cycle_a(1'b1, 1'b0, '0, 1'b1, 1'b0, "frz resume");
    chk("frz resume dout", int'(ifa.D_OUT), 16'hC002);
    cycle_a(1'b1, 1'b0, '0, 1'b1, 1'b0, "frz drain");

    // Asynchronous reset mid-cycle with 5 entries stored.
    for (int i = 0; i < 5; i++) cycle_a(1'b1, 1'b1, 16'hE000 + N'(i), 1'b0, 1'b0, "rst fill");
    ifa.R_IN = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async rst COUNT", int'(ifa.COUNT), 0);
    chk("async rst R_OUT", int'(ifa.R_OUT), 0);
    chk("async rst D_OUT", int'(ifa.D_OUT), 0);
    chk("async rst OVF",   int'(ifa.OVF), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle_a(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, "post rst");
    chk("post rst R_OUT", int'(ifa.R_OUT), 1);
    chk("post rst D_OUT", int'(ifa.D_OUT), 16'h1234);
    cycle_a(1'b1, 1'b0, '0, 1'b1, 1'b0, "post rst drain");

    // Decimation by 3 with idle gaps.
    for (int i = 0; i < 9; i++) begin
      cycle_b(1'b1, 1'b1, N'(10 + i), 1'b0);
      cycle_b(1'b1, 1'b0, '0, 1'b0);
    end
    chk("decim count", int'(ifb.COUNT), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("decim head%0d", i), int'(ifb.D_OUT), 10 + 3 * i);
      cycle_b(1'b1, 1'b0, '0, 1'b1);
    end
    chk("decim empty", int'(ifb.EMPTY), 1);
    for (int i = 0; i < 4; i++) cycle_b(1'b0, 1'b1, 16'h0099, 1'b1);
    chk("decim frz count", int'(ifb.COUNT), 0);
    cycle_b(1'b1, 1'b1, 16'h0077, 1'b0);
    cycle_b(1'b1, 1'b1, 16'h0078, 1'b0);
    chk("decim frz phase count", int'(ifb.COUNT), 1);
    chk("decim frz phase head", int'(ifb.D_OUT), 16'h0077);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 500; i++) begin
      cycle_a(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1, N'($urandom),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
